demux_route_ctrl: RTL

- Sequencing controller for the 1-to-4 demux datapath. Accepts one word at a time, with a 2-bit destination, over a valid/ready input handshake.
- Drives the demux select and a one-hot per-output valid, and holds the word until the addressed consumer accepts it.
- Drops the word on timeout, or when the destination is disabled. Sits between the upstream producer and the four demux output consumers.

---
 rtl/demux_route_ctrl_pkg.sv | 16 +
 rtl/demux_route_onehot.sv | 19 +
 rtl/demux_route_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/demux_route_ctrl_pkg.sv
// Shared constants for the 1-to-4 demux route controller: FSM encoding,
// channel count/width and a saturating counter helper.
package demux_route_ctrl_pkg;

    localparam int CH_N = 4;
    localparam int CH_W = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/demux_route_onehot.sv
// Purpose: 2-to-4 one-hot decoder gated by an enable, drives per-channel valid.
// Latency: purely combinational.
// Backpressure: none; output is all-zero whenever en is low.
module demux_route_onehot
    import demux_route_ctrl_pkg::*;
(
    input  logic [CH_W-1:0] sel,
    input  logic            en,
    output logic [CH_N-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_route_ctrl.sv
// Purpose: sequences one word at a time from a producer to one of four demux consumers.
// Latency: accept at edge N -> out_valid in cycle N+1; 2 cycles minimum per word.
// Backpressure: in_ready only in IDLE; word held until out_ready[sel] or timeout.
module demux_route_ctrl
    import demux_route_ctrl_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_dest,
    input  logic [CH_N-1:0]   en_mask,
    output logic [CH_W-1:0]   sel,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_N-1:0]   out_valid,
    input  logic [CH_N-1:0]   out_ready,
    output logic              drop_pulse,
    output logic              busy,
    output logic [7:0]        sent_cnt,
    output logic [7:0]        drop_cnt
);

    // Counter value seen in the last SEND cycle allowed before giving up.
    localparam logic [7:0] TMO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
    localparam bit         TMO_EN   = (TIMEOUT != 0);

    logic [1:0]        state_q, state_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        wait_q, wait_d;
    logic [7:0]        sent_q, sent_d;
    logic [7:0]        drop_q, drop_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        wait_d  = wait_q;
        sent_d  = sent_q;
        drop_d  = drop_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    sel_d   = in_dest;
                    wait_d  = 8'd0;
                    state_d = en_mask[in_dest] ? SEND : DROP;
                end
            end
            SEND: begin
                // Delivery is checked first so a ready in the final cycle beats the timeout.
                if (out_ready[sel_q]) begin
                    sent_d  = sent_q + 8'd1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (TMO_EN && (wait_q == TMO_LAST)) begin
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                drop_d  = sat_inc8(drop_q);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            wait_q  <= 8'd0;
            sent_q  <= 8'd0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
            sent_q  <= sent_d;
            drop_q  <= drop_d;
        end
    end

    demux_route_onehot u_onehot (
        .sel    (sel_q),
        .en     (state_q == SEND),
        .onehot (out_valid)
    );

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign drop_pulse = (state_q == DROP);
    assign sel        = sel_q;
    assign out_data   = data_q;
    assign sent_cnt   = sent_q;
    assign drop_cnt   = drop_q;

endmodule
